// File: rtl/warp_fetch.sv
// Fetch stage: issues 8-byte-aligned icache reads one at a time, splits responses into 32-bit instructions for decode.
// Optional WARP_FETCH_MISALIGN_EN adds o_fault for misaligned redirect targets; otherwise redirect pc[1:0] is forced to zero.
module warp_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_req_valid,
    output logic [63:0] o_req_raddr,
    input  logic        i_res_valid,
    input  logic [63:0] i_res_rdata,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [63:0] o_inst_pc,
    input  logic        i_inst_ready
`ifdef WARP_FETCH_MISALIGN_EN
    ,
    output logic        o_fault
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic          req_valid_q;
    logic [63:0]   req_raddr_q, raddr_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [63:0]   pc_mem_q   [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q, fifo_count;
    logic [AW-1:0] wr_idx, wr_idx1, rd_idx;
    logic          fifo_empty, pop, resp, push_one, push_two, issue, fault_blk;
    logic [1:0]    push_n;
    logic [AW+1:0] free_slots;
    logic [63:0]   redir_pc;

`ifdef WARP_FETCH_MISALIGN_EN
    logic fault_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fault_q <= 1'b0;
        end else if (i_redirect_valid) begin
            fault_q <= (i_redirect_pc[1:0] != 2'b00);
        end
    end

    assign fault_blk = fault_q;
    assign redir_pc  = i_redirect_pc;
    assign o_fault   = fault_q;
`else
    assign fault_blk = 1'b0;
    assign redir_pc  = i_redirect_pc & ~64'h3;
`endif

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign wr_idx1 = wr_idx + AW'(1);
    assign rd_idx  = rd_ptr_q[AW-1:0];

    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        pop        = !fifo_empty && i_inst_ready;
        resp       = (state_q == WAIT) && i_res_valid;
        push_two   = resp && !i_redirect_valid && !pc_q[2];
        push_one   = resp && !i_redirect_valid && pc_q[2];
        push_n     = {push_two, push_one};
        // Slots left after this cycle's pop and push; a new block may need two.
        free_slots = (AW+2)'(DEPTH) - (AW+2)'(fifo_count) + (AW+2)'(pop) - (AW+2)'(push_n);
        issue      = ((state_q == IDLE) || resp) && !i_redirect_valid && !fault_blk
                     && (free_slots >= (AW+2)'(2));

        pc_d = pc_q;
        if (i_redirect_valid) begin
            pc_d = redir_pc;
        end else if (push_two) begin
            pc_d = pc_q + 64'd8;
        end else if (push_one) begin
            pc_d = pc_q + 64'd4;
        end

        state_d = state_q;
        if (i_redirect_valid) begin
            state_d = (state_q == IDLE || i_res_valid) ? IDLE : DROP;
        end else begin
            case (state_q)
                IDLE:    state_d = issue ? WAIT : IDLE;
                WAIT:    state_d = i_res_valid ? (issue ? WAIT : IDLE) : WAIT;
                DROP:    state_d = i_res_valid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end

        // The icache matches tags against the live address, so hold it while a request is outstanding.
        raddr_d = req_raddr_q;
        if (issue || state_d == IDLE) begin
            raddr_d = {pc_d[63:3], 3'b000};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_raddr_q <= {RESET_PC[63:3], 3'b000};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= issue;
            req_raddr_q <= raddr_d;
            if (i_redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(push_n);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_two) begin
            inst_mem_q[wr_idx]  <= i_res_rdata[31:0];
            pc_mem_q[wr_idx]    <= pc_q;
            inst_mem_q[wr_idx1] <= i_res_rdata[63:32];
            pc_mem_q[wr_idx1]   <= pc_q + 64'd4;
        end else if (push_one) begin
            inst_mem_q[wr_idx]  <= i_res_rdata[63:32];
            pc_mem_q[wr_idx]    <= pc_q;
        end
    end

    assign o_req_valid  = req_valid_q;
    assign o_req_raddr  = req_raddr_q;
    assign o_inst_valid = !fifo_empty;
    assign o_inst       = fifo_empty ? 32'h0 : inst_mem_q[rd_idx];
    assign o_inst_pc    = fifo_empty ? 64'h0 : pc_mem_q[rd_idx];

endmodule

// File: tb/tb_warp_fetch.sv
// Bench for warp_fetch: icache model returns data as a function of address, decode stream checked against expected PC sequence.
module tb_warp_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_req_valid;
    logic [63:0] o_req_raddr;
    logic        i_res_valid;
    logic [63:0] i_res_rdata;
    logic        i_redirect_valid;
    logic [63:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic        i_inst_ready;
`ifdef WARP_FETCH_MISALIGN_EN
    logic        o_fault;
`endif

    warp_fetch #(.RESET_PC(64'h1000), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_req_valid(o_req_valid), .o_req_raddr(o_req_raddr),
        .i_res_valid(i_res_valid), .i_res_rdata(i_res_rdata),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_inst_ready(i_inst_ready)
`ifdef WARP_FETCH_MISALIGN_EN
        , .o_fault(o_fault)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    int          rdy_mode = 0;
    bit          pend = 0;
    logic [63:0] pend_addr;
    int          pend_cnt;
    logic [63:0] exp_pc = 64'h1000;
    int          pops = 0;
    bit          redir_req = 0;
    bit          redir_on_resp = 0;
    bit          redir_done = 0;
    logic [63:0] redir_tgt;
    bit          req_seen;
    int          req_cnt = 0;
    int          req_cyc;
    logic [63:0] last_req_addr;
    bit          tick_pop;
    logic [63:0] tick_pop_pc;

    typedef struct {
        logic [63:0] tgt;
        logic [63:0] req;
        logic [63:0] pc [3];
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] f(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        i_res_valid = 1'b0;
        i_res_rdata = 64'h0;
        if (pend && pend_cnt == 0) begin
            i_res_valid = 1'b1;
            i_res_rdata = {f(o_req_raddr + 64'd4), f(o_req_raddr)};
        end
        case (rdy_mode)
            0:       i_inst_ready = 1'b1;
            1:       i_inst_ready = 1'b0;
            default: i_inst_ready = ($urandom_range(0, 3) != 0);
        endcase
        i_redirect_valid = 1'b0;
        i_redirect_pc    = redir_tgt;
        if (redir_req) begin
            i_redirect_valid = 1'b1;
            redir_req = 0;
        end else if (redir_on_resp && i_res_valid) begin
            i_redirect_valid = 1'b1;
            redir_on_resp = 0;
            redir_done = 1;
        end
        if (pend) check("raddr_stable", o_req_raddr, pend_addr);
        tick_pop = 0;
        if (o_inst_valid && i_inst_ready && !i_redirect_valid) begin
            check("pop_pc", o_inst_pc, exp_pc);
            check("pop_inst", {32'h0, o_inst}, {32'h0, f(exp_pc)});
            tick_pop = 1;
            tick_pop_pc = o_inst_pc;
            exp_pc = exp_pc + 64'd4;
            pops++;
        end
        if (i_redirect_valid) begin
`ifdef WARP_FETCH_MISALIGN_EN
            exp_pc = i_redirect_pc;
`else
            exp_pc = i_redirect_pc & ~64'h3;
`endif
        end
        if (i_res_valid) pend = 0;
        else if (pend) pend_cnt--;
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_req_valid) begin
            check("one_outstanding", {63'h0, pend}, 64'h0);
            check("req_aligned", {61'h0, o_req_raddr[2:0]}, 64'h0);
            if (rand_lat) lat = $urandom_range(1, 4);
            pend = 1;
            pend_addr = o_req_raddr;
            pend_cnt = lat;
            req_seen = 1;
            req_cnt++;
            req_cyc = cyc;
            last_req_addr = o_req_raddr;
        end
    endtask

    task automatic wait_req(input int bound, output bit ok, output logic [63:0] addr);
        req_seen = 0;
        for (int i = 0; i < bound && !req_seen; i++) tick();
        ok = req_seen;
        addr = last_req_addr;
    endtask

    task automatic wait_pop(input int bound, output bit ok, output logic [63:0] pc);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            ok = tick_pop;
        end
        pc = tick_pop_pc;
    endtask

    bit          ok;
    logic [63:0] a;
    int          c1, n, pops0;

    initial begin
        vecs.push_back('{tgt: 64'h2004, req: 64'h2000, pc: '{64'h2004, 64'h2008, 64'h200C}});
        vecs.push_back('{tgt: 64'hFFFF_FFFF_FFFF_FFFC, req: 64'hFFFF_FFFF_FFFF_FFF8,
                         pc: '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4}});
        vecs.push_back('{tgt: 64'hFFFF_FFFF_FFFF_FFF8, req: 64'hFFFF_FFFF_FFFF_FFF8,
                         pc: '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0}});
        vecs.push_back('{tgt: 64'h4000, req: 64'h4000, pc: '{64'h4000, 64'h4004, 64'h4008}});
`ifndef WARP_FETCH_MISALIGN_EN
        vecs.push_back('{tgt: 64'h3006, req: 64'h3000, pc: '{64'h3004, 64'h3008, 64'h300C}});
`endif

        i_rst_n = 1'b0;
        i_res_valid = 0; i_res_rdata = 0; i_redirect_valid = 0; i_redirect_pc = 0; i_inst_ready = 0;
        redir_tgt = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_req_valid", {63'h0, o_req_valid}, 64'h0);
        check("rst_req_raddr", o_req_raddr, 64'h1000);
        check("rst_inst_valid", {63'h0, o_inst_valid}, 64'h0);
        check("rst_inst", {32'h0, o_inst}, 64'h0);
        check("rst_inst_pc", o_inst_pc, 64'h0);
        i_rst_n = 1'b1;

        // Startup stream with 1-cycle hits.
        wait_req(10, ok, a);
        check("start_req_seen", {63'h0, ok}, 64'h1);
        check("start_req0", a, 64'h1000);
        c1 = req_cyc;
        wait_req(10, ok, a);
        check("start_req1", a, 64'h1008);
        check("start_spacing", 64'(req_cyc - c1), 64'd2);
        repeat (10) tick();
        check("start_progress", {63'h0, (pops >= 6)}, 64'h1);

        foreach (vecs[k]) begin
            redir_req = 1;
            redir_tgt = vecs[k].tgt;
            tick();
            wait_req(20, ok, a);
            check("vec_req", a, vecs[k].req);
            for (int j = 0; j < 3; j++) begin
                wait_pop(20, ok, a);
                check("vec_pop_seen", {63'h0, ok}, 64'h1);
                check("vec_pc", a, vecs[k].pc[j]);
            end
        end

        // Redirect during a long miss.
        lat = 10;
        wait_req(20, ok, a);
        repeat (3) tick();
        redir_req = 1;
        redir_tgt = 64'h5000;
        req_cnt = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = !pend;
        end
        check("miss_resp_seen", {63'h0, ok}, 64'h1);
        check("miss_no_req", 64'(req_cnt), 64'h0);
        wait_req(10, ok, a);
        check("miss_req", a, 64'h5000);
        wait_pop(30, ok, a);
        check("miss_pop", a, 64'h5000);

        // Redirect in the same cycle as a response.
        lat = 1;
        redir_tgt = 64'h7000;
        redir_on_resp = 1;
        redir_done = 0;
        for (int i = 0; i < 20 && !redir_done; i++) tick();
        check("same_done", {63'h0, redir_done}, 64'h1);
        check("same_empty", {63'h0, o_inst_valid}, 64'h0);
        check("same_no_req", {63'h0, o_req_valid}, 64'h0);
        tick();
        check("same_req_valid", {63'h0, o_req_valid}, 64'h1);
        check("same_req_addr", o_req_raddr, 64'h7000);

        // Stalled decode fills the FIFO, then drains.
        lat = 10;
        rdy_mode = 1;
        redir_req = 1;
        redir_tgt = 64'h6000;
        tick();
        repeat (40) tick();
        req_cnt = 0;
        check("fill_head_pc0", o_inst_pc, 64'h6000);
        repeat (30) tick();
        check("fill_no_req", 64'(req_cnt), 64'h0);
        check("fill_valid", {63'h0, o_inst_valid}, 64'h1);
        check("fill_head_pc1", o_inst_pc, 64'h6000);
        check("fill_head_inst", {32'h0, o_inst}, {32'h0, f(64'h6000)});
        rdy_mode = 0;
        req_cnt = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!tick_pop) break;
            n++;
        end
        check("fill_depth", 64'(n), 64'd4);
        check("drain_resume", {63'h0, (req_cnt != 0)}, 64'h1);
        wait_pop(30, ok, a);
        check("drain_next_pc", a, 64'h6010);

`ifdef WARP_FETCH_MISALIGN_EN
        lat = 1;
        redir_req = 1;
        redir_tgt = 64'h3002;
        tick();
        check("fault_set", {63'h0, o_fault}, 64'h1);
        req_cnt = 0;
        repeat (20) tick();
        check("fault_no_req", 64'(req_cnt), 64'h0);
        check("fault_empty", {63'h0, o_inst_valid}, 64'h0);
        redir_req = 1;
        redir_tgt = 64'h3000;
        tick();
        check("fault_clear", {63'h0, o_fault}, 64'h0);
        wait_req(10, ok, a);
        check("fault_resume_req", a, 64'h3000);
        wait_pop(20, ok, a);
        check("fault_resume_pc", a, 64'h3000);
`endif

        // Randomised traffic against the stream model.
        rand_lat = 1;
        rdy_mode = 2;
        pops0 = pops;
        for (int i = 0; i < 2500; i++) begin
            if (!redir_req && !redir_on_resp && $urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    redir_tgt = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
                else
                    redir_tgt = 64'h1_0000 + 64'($urandom_range(0, 65535));
`ifdef WARP_FETCH_MISALIGN_EN
                redir_tgt = redir_tgt & ~64'h3;
`endif
                if ($urandom_range(0, 1) == 0) redir_req = 1;
                else redir_on_resp = 1;
            end
            tick();
        end
        check("rand_progress", {63'h0, ((pops - pops0) > 200)}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
